rob_commit: RTL and testbench

//  Reorder buffer with in-order, 2-wide retirement; sits directly upstream of the architectural register file.

---
 rtl/rob_commit.sv | 149 ++++++++++++++
 tb/tb_rob_commit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// Reorder buffer with 2-wide dispatch allocation, 2 writeback ports and
// in-order 2-wide retirement driving the architectural register file.
module rob_commit #(
  parameter int DEPTH  = 64,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 16,
  parameter int AREG_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc0_valid,
  input  logic              alloc0_wr,
  input  logic [AREG_W-1:0] alloc0_dest,
  input  logic              alloc1_valid,
  input  logic              alloc1_wr,
  input  logic [AREG_W-1:0] alloc1_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc0_tag,
  output logic [TAG_W-1:0]  alloc1_tag,
  input  logic              wb0_valid,
  input  logic [TAG_W-1:0]  wb0_tag,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_valid,
  input  logic [TAG_W-1:0]  wb1_tag,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wen0,
  output logic [AREG_W-1:0] waddr0,
  output logic [DATA_W-1:0] wdata0,
  output logic              wen1,
  output logic [AREG_W-1:0] waddr1,
  output logic [DATA_W-1:0] wdata1,
  output logic [TAG_W:0]    count
);

  // Allocation needs room for two entries; the check uses registered count only.
  localparam logic [TAG_W:0] READY_MAX = (TAG_W+1)'(DEPTH - 2);

  // Per-entry status bits (reset) and payload (not reset).
  logic [DEPTH-1:0]  valid_q, done_q, wr_q;
  logic [AREG_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [TAG_W-1:0]  head_q, tail_q;
  logic [TAG_W:0]    count_q, count_d;
  logic [TAG_W-1:0]  head1, tail1;

  logic              wen0_q, wen1_q;
  logic [AREG_W-1:0] waddr0_q, waddr1_q;
  logic [DATA_W-1:0] wdata0_q, wdata1_q;

  logic acc0, acc1, ret0, ret1, wb0_hit, wb1_hit;

  assign alloc_ready = (count_q <= READY_MAX);
  assign alloc0_tag  = tail_q;
  assign alloc1_tag  = tail1;
  assign count       = count_q;
  assign wen0        = wen0_q;
  assign waddr0      = waddr0_q;
  assign wdata0      = wdata0_q;
  assign wen1        = wen1_q;
  assign waddr1      = waddr1_q;
  assign wdata1      = wdata1_q;

  // Per-cycle accept / writeback / retire decisions from registered state; flush gates all of them.
  always_comb begin
    // NOTE: every signal gets a value on every path here so no latch is inferred.
    head1   = head_q + TAG_W'(1);
    tail1   = tail_q + TAG_W'(1);
    acc0    = alloc0_valid & alloc_ready & ~flush;
    acc1    = acc0 & alloc1_valid;
    ret0    = ~flush & valid_q[head_q] & done_q[head_q];
    ret1    = ret0 & valid_q[head1] & done_q[head1];
    wb0_hit = ~flush & wb0_valid & valid_q[wb0_tag];
    wb1_hit = ~flush & wb1_valid & valid_q[wb1_tag];
    count_d = count_q + (TAG_W+1)'(acc0) + (TAG_W+1)'(acc1)
                      - (TAG_W+1)'(ret0) - (TAG_W+1)'(ret1);
  end

  // Pointers, entry status and registered commit ports.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      valid_q  <= '0;
      done_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wen0_q   <= 1'b0;
      wen1_q   <= 1'b0;
      waddr0_q <= '0;
      waddr1_q <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
    end else if (flush) begin
      valid_q  <= '0;
      done_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wen0_q   <= 1'b0;
      wen1_q   <= 1'b0;
      waddr0_q <= '0;
      waddr1_q <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
    end else begin
      // Retire and allocate never touch the same entry: alloc targets are invalid, retire targets valid.
      if (ret0) valid_q[head_q] <= 1'b0;
      if (ret1) valid_q[head1]  <= 1'b0;
      if (wb1_hit) done_q[wb1_tag] <= 1'b1;
      if (wb0_hit) done_q[wb0_tag] <= 1'b1;
      if (acc0) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
      end
      if (acc1) begin
        valid_q[tail1] <= 1'b1;
        done_q[tail1]  <= 1'b0;
      end
      head_q  <= head_q + TAG_W'(ret0) + TAG_W'(ret1);
      tail_q  <= tail_q + TAG_W'(acc0) + TAG_W'(acc1);
      count_q <= count_d;
      // Slot 0 is always the older instruction; a lone retirement uses slot 0.
      wen0_q   <= ret0 & wr_q[head_q];
      waddr0_q <= ret0 ? dest_q[head_q] : '0;
      wdata0_q <= ret0 ? data_q[head_q] : '0;
      wen1_q   <= ret1 & wr_q[head1];
      waddr1_q <= ret1 ? dest_q[head1] : '0;
      wdata1_q <= ret1 ? data_q[head1] : '0;
    end
  end

  // Entry payload: dispatch fields on allocation, result on writeback (wb0 written last so it wins).
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; it is only read once the matching valid/done bits are set.
    if (acc0) begin
      wr_q[tail_q]   <= alloc0_wr;
      dest_q[tail_q] <= alloc0_dest;
    end
    if (acc1) begin
      wr_q[tail1]   <= alloc1_wr;
      dest_q[tail1] <= alloc1_dest;
    end
    if (wb1_hit) data_q[wb1_tag] <= wb1_data;
    if (wb0_hit) data_q[wb0_tag] <= wb0_data;
  end

endmodule

// File: tb/tb_rob_commit.sv
// Randomized plus directed bench for rob_commit against a program-order queue model.
module tb_rob_commit;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alloc0_valid, alloc0_wr, alloc1_valid, alloc1_wr;
  logic [2:0]  alloc0_dest, alloc1_dest;
  logic        alloc_ready;
  logic [5:0]  alloc0_tag, alloc1_tag;
  logic        wb0_valid, wb1_valid;
  logic [5:0]  wb0_tag, wb1_tag;
  logic [15:0] wb0_data, wb1_data;
  logic        wen0, wen1;
  logic [2:0]  waddr0, waddr1;
  logic [15:0] wdata0, wdata1;
  logic [6:0]  count;

  rob_commit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc0_valid(alloc0_valid), .alloc0_wr(alloc0_wr), .alloc0_dest(alloc0_dest),
    .alloc1_valid(alloc1_valid), .alloc1_wr(alloc1_wr), .alloc1_dest(alloc1_dest),
    .alloc_ready(alloc_ready), .alloc0_tag(alloc0_tag), .alloc1_tag(alloc1_tag),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: live instructions in program order.
  typedef struct {
    int          tag;
    bit          wr;
    logic [2:0]  dest;
    bit          done;
    logic [15:0] data;
  } entry_t;

  entry_t rob[$];
  int     tail = 0;
  int     n_checks = 0;
  int     n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic clr_in();
    flush = 0;
    alloc0_valid = 0; alloc0_wr = 0; alloc0_dest = 0;
    alloc1_valid = 0; alloc1_wr = 0; alloc1_dest = 0;
    wb0_valid = 0; wb0_tag = 0; wb0_data = 0;
    wb1_valid = 0; wb1_tag = 0; wb1_data = 0;
  endtask

  task automatic model_clear();
    rob.delete();
    tail = 0;
  endtask

  function automatic void apply_wb(input int tag, input logic [15:0] data);
    foreach (rob[i]) if (rob[i].tag == tag) begin
      rob[i].done = 1;
      rob[i].data = data;
    end
  endfunction

  // One clock: compare pre-edge outputs, advance model, compare commit ports after the edge.
  task automatic cycle();
    entry_t e0, e1, n;
    int     nret;
    bit     ready, exp_w0, exp_w1;
    ready = (DEPTH - rob.size()) >= 2;
    check("count", 32'(count), rob.size());
    check("alloc_ready", 32'(alloc_ready), 32'(ready));
    check("alloc0_tag", 32'(alloc0_tag), tail);
    check("alloc1_tag", 32'(alloc1_tag), (tail + 1) % DEPTH);
    nret = 0;
    e0 = '{default: 0};
    e1 = '{default: 0};
    if (flush) begin
      model_clear();
    end else begin
      if (rob.size() > 0 && rob[0].done) begin
        e0 = rob[0]; nret = 1;
        if (rob.size() > 1 && rob[1].done) begin
          e1 = rob[1]; nret = 2;
        end
      end
      if (wb1_valid) apply_wb(int'(wb1_tag), wb1_data);
      if (wb0_valid) apply_wb(int'(wb0_tag), wb0_data);
      repeat (nret) void'(rob.pop_front());
      if (alloc0_valid && ready) begin
        n = '{tag: tail, wr: alloc0_wr, dest: alloc0_dest, done: 0, data: 0};
        rob.push_back(n);
        tail = (tail + 1) % DEPTH;
        if (alloc1_valid) begin
          n = '{tag: tail, wr: alloc1_wr, dest: alloc1_dest, done: 0, data: 0};
          rob.push_back(n);
          tail = (tail + 1) % DEPTH;
        end
      end
    end
    exp_w0 = (nret >= 1) && e0.wr;
    exp_w1 = (nret == 2) && e1.wr;
    @(posedge clk);
    #1;
    check("wen0", 32'(wen0), 32'(exp_w0));
    check("wen1", 32'(wen1), 32'(exp_w1));
    if (exp_w0) begin
      check("waddr0", 32'(waddr0), 32'(e0.dest));
      check("wdata0", 32'(wdata0), 32'(e0.data));
    end
    if (exp_w1) begin
      check("waddr1", 32'(waddr1), 32'(e1.dest));
      check("wdata1", 32'(wdata1), 32'(e1.data));
    end
  endtask

  task automatic do_flush();
    clr_in(); flush = 1; cycle(); clr_in();
  endtask

  task automatic alloc2(input bit wr, input logic [2:0] d0, input logic [2:0] d1);
    clr_in();
    alloc0_valid = 1; alloc0_wr = wr; alloc0_dest = d0;
    alloc1_valid = 1; alloc1_wr = wr; alloc1_dest = d1;
    cycle(); clr_in();
  endtask

  task automatic wb2(input int t0, input logic [15:0] d0, input int t1, input logic [15:0] d1);
    clr_in();
    wb0_valid = 1; wb0_tag = 6'(t0); wb0_data = d0;
    wb1_valid = 1; wb1_tag = 6'(t1); wb1_data = d1;
    cycle(); clr_in();
  endtask

  task automatic wb1only(input int t0, input logic [15:0] d0);
    clr_in();
    wb0_valid = 1; wb0_tag = 6'(t0); wb0_data = d0;
    cycle(); clr_in();
  endtask

  task automatic idle(input int n);
    clr_in();
    repeat (n) cycle();
  endtask

  initial begin
    clr_in();
    rst_n = 0;
    #22;
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(alloc_ready), 1);
    check("rst_wen0", 32'(wen0), 0);
    check("rst_wen1", 32'(wen1), 0);
    @(negedge clk); rst_n = 1;
    model_clear();

    // Two-entry out-of-order completion, paired commit.
    alloc2(1, 3'd3, 3'd5);
    wb1only(1, 16'h00BB);
    idle(1);
    wb1only(0, 16'h00AA);
    idle(2);

    // Fill to 64, then a single retirement.
    do_flush();
    for (int i = 0; i < 32; i++) alloc2(1, 3'($urandom), 3'($urandom));
    check("full_count", 32'(count), 64);
    check("full_ready", 32'(alloc_ready), 0);
    wb1only(0, 16'h1234);
    idle(2);
    check("after_one_count", 32'(count), 63);
    check("after_one_ready", 32'(alloc_ready), 0);

    // Pointer wrap: advance head/tail to 62 through completed wr=0 entries.
    do_flush();
    for (int i = 0; i < 31; i++) begin
      clr_in();
      alloc0_valid = 1; alloc1_valid = 1;
      if (i > 0) begin
        wb0_valid = 1; wb0_tag = 6'(2*i - 2);
        wb1_valid = 1; wb1_tag = 6'(2*i - 1);
      end
      cycle();
    end
    wb2(60, 16'h0, 61, 16'h0);
    idle(2);
    check("wrap_tag", 32'(alloc0_tag), 62);
    alloc2(1, 3'd1, 3'd2);
    alloc2(1, 3'd3, 3'd4);
    wb2(63, 16'h6363, 62, 16'h6262);
    wb2(0, 16'h0A0A, 1, 16'h0101);
    idle(3);

    // Same-tag writeback priority and a writeback to an invalid tag.
    do_flush();
    for (int i = 0; i < 3; i++) alloc2(1, 3'(2*i), 3'(2*i + 1));
    wb2(5, 16'h1111, 5, 16'h2222);
    wb1only(9, 16'hDEAD);
    check("inv_count", 32'(count), 6);
    wb2(0, 16'h0100, 1, 16'h0101);
    wb2(2, 16'h0102, 3, 16'h0103);
    wb1only(4, 16'h0104);
    idle(4);

    // Flush colliding with alloc, wb and a retirable head.
    do_flush();
    alloc2(1, 3'd6, 3'd7);
    wb1only(0, 16'h5555);
    clr_in();
    flush = 1; alloc0_valid = 1; alloc0_wr = 1; alloc1_valid = 1;
    wb0_valid = 1; wb0_tag = 6'd1; wb0_data = 16'h7777;
    cycle();
    idle(2);

    // Asynchronous reset with 10 live entries.
    for (int i = 0; i < 5; i++) alloc2(1, 3'($urandom), 3'($urandom));
    wb1only(0, 16'h4444);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_wen0", 32'(wen0), 0);
    check("mid_rst_wen1", 32'(wen1), 0);
    check("mid_rst_tag", 32'(alloc0_tag), 0);
    check("mid_rst_ready", 32'(alloc_ready), 1);
    model_clear();
    @(negedge clk); rst_n = 1;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      clr_in();
      flush        = ($urandom_range(0, 99) == 0);
      alloc0_valid = ($urandom_range(0, 99) < 55);
      alloc1_valid = $urandom_range(0, 1) == 1;
      alloc0_wr    = ($urandom_range(0, 3) != 0);
      alloc1_wr    = ($urandom_range(0, 3) != 0);
      alloc0_dest  = 3'($urandom);
      alloc1_dest  = 3'($urandom);
      wb0_valid    = $urandom_range(0, 1) == 1;
      wb1_valid    = $urandom_range(0, 1) == 1;
      wb0_data     = 16'($urandom);
      wb1_data     = 16'($urandom);
      if (rob.size() > 0 && $urandom_range(0, 9) < 8) wb0_tag = 6'(rob[$urandom_range(0, rob.size()-1)].tag);
      else wb0_tag = 6'($urandom);
      if (rob.size() > 0 && $urandom_range(0, 9) < 8) wb1_tag = 6'(rob[$urandom_range(0, rob.size()-1)].tag);
      else wb1_tag = 6'($urandom);
      cycle();
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
